// File: rtl/isa_types.sv
// Shared ISA-level types for the data-memory access path: XLEN, load/store funct3
// encodings, LSU state encoding and access widths.
package isa_types;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_RESP
    } lsu_state_t;

    typedef enum logic [1:0] {
        MEM_BYTE,
        MEM_HALF,
        MEM_WORD
    } mem_width_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering for the LSU: byte enables, store-data shift,
// right-justified load extraction and access legality.
module lsu_lane_align
    import isa_types::*;
(
    input  logic            is_store_i,
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [XLEN-1:0] store_data_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic [3:0]      mem_be_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic [XLEN-1:0] load_data_o,
    output logic            illegal_o
);

    mem_width_t      width;
    logic [4:0]      shamt;
    logic [XLEN-1:0] shifted;
    logic            f3_ok;
    logic            misaligned;

    assign shamt       = {addr_lo_i, 3'b000};
    assign shifted     = mem_rdata_i >> shamt;
    assign mem_wdata_o = store_data_i << shamt;

    always_comb begin
        width = MEM_WORD;
        unique case (funct3_i[1:0])
            2'b00:   width = MEM_BYTE;
            2'b01:   width = MEM_HALF;
            default: width = MEM_WORD;
        endcase
    end

    always_comb begin
        mem_be_o    = 4'b1111;
        load_data_o = shifted;
        unique case (width)
            MEM_BYTE: begin
                mem_be_o    = 4'b0001 << addr_lo_i;
                load_data_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
            end
            MEM_HALF: begin
                mem_be_o    = 4'b0011 << addr_lo_i;
                load_data_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
            end
            default: begin
                mem_be_o    = 4'b1111;
                load_data_o = shifted;
            end
        endcase
    end

    always_comb begin
        if (is_store_i) begin
            f3_ok = funct3_i inside {FUNCT3_SB, FUNCT3_SH, FUNCT3_SW};
        end else begin
            f3_ok = funct3_i inside {FUNCT3_LB, FUNCT3_LH, FUNCT3_LW, FUNCT3_LBU, FUNCT3_LHU};
        end
        misaligned = ((width == MEM_HALF) && addr_lo_i[0]) ||
                     ((width == MEM_WORD) && (addr_lo_i != 2'b00));
        illegal_o  = !f3_ok || misaligned;
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store stage: captures one request, drives the memory bus with a ready/valid
// handshake and timeout, and returns the right-justified raw load value.
module load_store_unit
    import isa_types::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            is_store,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] store_data,
    output logic            busy,
    output logic            done,
    output logic            fault,
    output logic [XLEN-1:0] load_val,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CntW:0] Limit = (CntW + 1)'(TIMEOUT_CYCLES);

    lsu_state_t      state_q, state_d;
    logic            is_store_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] sdata_q;
    logic [XLEN-1:0] load_val_q, load_val_d;
    logic            fault_q, fault_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW:0]   cnt_inc;
    logic            idle;
    logic            capture;

    logic            al_is_store;
    logic [2:0]      al_funct3;
    logic [1:0]      al_addr_lo;
    logic [XLEN-1:0] al_sdata;
    logic [3:0]      al_be;
    logic [XLEN-1:0] al_wdata;
    logic [XLEN-1:0] al_load;
    logic            al_illegal;

    assign idle    = (state_q == LSU_IDLE);
    assign capture = idle && start;
    assign cnt_inc = {1'b0, cnt_q} + 1'b1;

    // In IDLE the aligner looks at the live request so legality is known at accept time;
    // afterwards it works from the captured copy so bus outputs stay stable.
    always_comb begin
        al_is_store = idle ? is_store   : is_store_q;
        al_funct3   = idle ? funct3     : funct3_q;
        al_addr_lo  = idle ? addr[1:0]  : addr_q[1:0];
        al_sdata    = idle ? store_data : sdata_q;
    end

    lsu_lane_align u_align (
        .is_store_i   (al_is_store),
        .funct3_i     (al_funct3),
        .addr_lo_i    (al_addr_lo),
        .store_data_i (al_sdata),
        .mem_rdata_i  (mem_rdata),
        .mem_be_o     (al_be),
        .mem_wdata_o  (al_wdata),
        .load_data_o  (al_load),
        .illegal_o    (al_illegal)
    );

    always_comb begin
        state_d    = state_q;
        fault_d    = fault_q;
        cnt_d      = cnt_q;
        load_val_d = load_val_q;
        unique case (state_q)
            LSU_IDLE: begin
                if (start) begin
                    fault_d = al_illegal;
                    cnt_d   = '0;
                    state_d = al_illegal ? LSU_RESP : LSU_REQ;
                end
            end
            LSU_REQ: begin
                if (mem_ready) begin
                    if (!is_store_q) begin
                        load_val_d = al_load;
                    end
                    fault_d = 1'b0;
                    cnt_d   = '0;
                    state_d = LSU_RESP;
                end else if (TIMEOUT_CYCLES != 0) begin
                    if (cnt_inc == Limit) begin
                        fault_d = 1'b1;
                        cnt_d   = '0;
                        state_d = LSU_RESP;
                    end else begin
                        cnt_d = cnt_inc[CntW-1:0];
                    end
                end
            end
            LSU_RESP: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= LSU_IDLE;
            fault_q    <= 1'b0;
            cnt_q      <= '0;
            load_val_q <= '0;
            is_store_q <= 1'b0;
            funct3_q   <= '0;
            addr_q     <= '0;
            sdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            fault_q    <= fault_d;
            cnt_q      <= cnt_d;
            load_val_q <= load_val_d;
            if (capture) begin
                is_store_q <= is_store;
                funct3_q   <= funct3;
                addr_q     <= addr;
                sdata_q    <= store_data;
            end
        end
    end

    always_comb begin
        busy      = !idle;
        done      = (state_q == LSU_RESP);
        fault     = done && fault_q;
        load_val  = load_val_q;
        mem_req   = (state_q == LSU_REQ);
        mem_we    = mem_req && is_store_q;
        mem_addr  = {addr_q[XLEN-1:2], 2'b00};
        mem_be    = mem_req ? al_be : 4'b0000;
        mem_wdata = mem_req ? al_wdata : '0;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit: alignment, handshake latency,
// misaligned/illegal faults, timeout, back-to-back and mid-transaction reset.
module tb_load_store_unit;
    import isa_types::*;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            start;
    logic            is_store;
    logic [2:0]      funct3;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] store_data;
    logic            busy;
    logic            done;
    logic            fault;
    logic [XLEN-1:0] load_val;
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [3:0]      mem_be;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_ready;
    logic [XLEN-1:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .fault      (fault),
        .load_val   (load_val),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for one edge; returns in the cycle after the accept edge.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d);
        start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = d;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step(); step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", fault); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", mem_req); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", mem_we); end
        checks++; if (mem_be !== 4'b0000) begin errors++; $display("FAIL reset_be: got %b want 0000", mem_be); end
        checks++; if (load_val !== 32'h0) begin errors++; $display("FAIL reset_load_val: got %h want 0", load_val); end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_sw();
        issue(1'b1, FUNCT3_SW, 32'h104, 32'hDEADBEEF);
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL sw_req: got %b want 1", mem_req); end
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL sw_we: got %b want 1", mem_we); end
        checks++; if (mem_addr !== 32'h104) begin errors++; $display("FAIL sw_addr: got %h want 00000104", mem_addr); end
        checks++; if (mem_be !== 4'b1111) begin errors++; $display("FAIL sw_be: got %b want 1111", mem_be); end
        checks++; if (mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata: got %h want deadbeef", mem_wdata); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL sw_early_done: got %b want 0", done); end
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL sw_done: got %b want 1", done); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL sw_fault: got %b want 0", fault); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL sw_req_drop: got %b want 0", mem_req); end
        checks++; if (load_val !== 32'h0) begin errors++; $display("FAIL sw_load_val: got %h want 0", load_val); end
        step();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL sw_idle: got done=%b busy=%b want 0 0", done, busy); end
    endtask

    task automatic test_sb();
        issue(1'b1, FUNCT3_SB, 32'h203, 32'h000000A5);
        checks++; if (mem_addr !== 32'h200) begin errors++; $display("FAIL sb_addr: got %h want 00000200", mem_addr); end
        checks++; if (mem_be !== 4'b1000) begin errors++; $display("FAIL sb_be: got %b want 1000", mem_be); end
        checks++; if (mem_wdata !== 32'hA5000000) begin errors++; $display("FAIL sb_wdata: got %h want a5000000", mem_wdata); end
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL sb_done: got %b want 1", done); end
        step();
    endtask

    task automatic test_lh_delayed();
        issue(1'b0, FUNCT3_LH, 32'h302, 32'h0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h300 ||
                mem_be !== 4'b1100 || done !== 1'b0) begin
                errors++;
                $display("FAIL lh_hold%0d: got req=%b we=%b addr=%h be=%b done=%b want 1 0 00000300 1100 0",
                         i, mem_req, mem_we, mem_addr, mem_be, done);
            end
            step();
        end
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL lh_req4: got %b want 1", mem_req); end
        mem_ready = 1'b1;
        mem_rdata = 32'hBEEF1234;
        step();
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        checks++; if (done !== 1'b1 || fault !== 1'b0) begin errors++; $display("FAIL lh_done: got done=%b fault=%b want 1 0", done, fault); end
        checks++; if (load_val !== 32'h0000BEEF) begin errors++; $display("FAIL lh_load_val: got %h want 0000beef", load_val); end
        step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL lh_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_misaligned();
        issue(1'b0, FUNCT3_LW, 32'h101, 32'h0);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL mis_req: got %b want 0", mem_req); end
        checks++; if (done !== 1'b1 || fault !== 1'b1) begin errors++; $display("FAIL mis_done: got done=%b fault=%b want 1 1", done, fault); end
        checks++; if (load_val !== 32'h0000BEEF) begin errors++; $display("FAIL mis_load_val: got %h want 0000beef", load_val); end
        step();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mis_idle: got done=%b busy=%b want 0 0", done, busy); end
    endtask

    task automatic test_illegal_funct3();
        issue(1'b1, 3'b100, 32'h100, 32'h1);
        checks++; if (done !== 1'b1 || fault !== 1'b1 || mem_req !== 1'b0) begin
            errors++; $display("FAIL ill_f3: got done=%b fault=%b req=%b want 1 1 0", done, fault, mem_req);
        end
        step();
        issue(1'b0, FUNCT3_LHU, 32'h102, 32'h0);
        checks++; if (mem_req !== 1'b1 || mem_be !== 4'b1100) begin
            errors++; $display("FAIL lhu_legal: got req=%b be=%b want 1 1100", mem_req, mem_be);
        end
        mem_ready = 1'b1;
        mem_rdata = 32'h8001BEEF;
        step();
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        checks++; if (load_val !== 32'h00008001) begin errors++; $display("FAIL lhu_load_val: got %h want 00008001", load_val); end
        step();
        issue(1'b0, FUNCT3_LH, 32'h302, 32'h0);
        mem_ready = 1'b1;
        mem_rdata = 32'hBEEF1234;
        step();
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        step();
    endtask

    task automatic test_timeout();
        int n;
        issue(1'b0, FUNCT3_LB, 32'h400, 32'h0);
        n = 0;
        while (mem_req === 1'b1 && n < 40) begin
            n++;
            step();
        end
        checks++; if (n !== 16) begin errors++; $display("FAIL to_req_cycles: got %0d want 16", n); end
        checks++; if (done !== 1'b1 || fault !== 1'b1) begin errors++; $display("FAIL to_fault: got done=%b fault=%b want 1 1", done, fault); end
        checks++; if (load_val !== 32'h0000BEEF) begin errors++; $display("FAIL to_load_val: got %h want 0000beef", load_val); end
        step();
        issue(1'b0, FUNCT3_LB, 32'h400, 32'h0);
        for (int i = 0; i < 15; i++) step();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL to16_req: got %b want 1", mem_req); end
        mem_ready = 1'b1;
        mem_rdata = 32'h112233C4;
        step();
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        checks++; if (done !== 1'b1 || fault !== 1'b0) begin errors++; $display("FAIL to16_win: got done=%b fault=%b want 1 0", done, fault); end
        checks++; if (load_val !== 32'h000000C4) begin errors++; $display("FAIL to16_load_val: got %h want 000000c4", load_val); end
        step();
    endtask

    task automatic test_back_to_back();
        issue(1'b1, FUNCT3_SW, 32'h104, 32'h12345678);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        start = 1'b1; is_store = 1'b1; funct3 = FUNCT3_SW; addr = 32'h108; store_data = 32'hCAFEF00D;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b want 1", done); end
        step();
        checks++; if (busy !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL b2b_ignored: got busy=%b req=%b want 0 0", busy, mem_req); end
        step();
        start = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h108 || mem_wdata !== 32'hCAFEF00D) begin
            errors++; $display("FAIL b2b_accept: got req=%b addr=%h wdata=%h want 1 00000108 cafef00d", mem_req, mem_addr, mem_wdata);
        end
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        step();
    endtask

    task automatic test_ready_outside_req();
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        step(); step();
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || load_val !== 32'h000000C4) begin
            errors++; $display("FAIL idle_ready: got busy=%b done=%b load_val=%h want 0 0 000000c4", busy, done, load_val);
        end
    endtask

    task automatic test_reset_mid();
        issue(1'b0, FUNCT3_LB, 32'h400, 32'h0);
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        checks++; if (busy !== 1'b0 || mem_req !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL rst_mid: got busy=%b req=%b done=%b want 0 0 0", busy, mem_req, done);
        end
        step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_no_done: got %b want 0", done); end
        issue(1'b0, FUNCT3_LBU, 32'h001, 32'h0);
        checks++; if (mem_be !== 4'b0010 || mem_addr !== 32'h0) begin
            errors++; $display("FAIL lbu_bus: got be=%b addr=%h want 0010 00000000", mem_be, mem_addr);
        end
        mem_ready = 1'b1;
        mem_rdata = 32'h0000FF00;
        step();
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        checks++; if (load_val !== 32'h000000FF || done !== 1'b1) begin
            errors++; $display("FAIL lbu_load_val: got %h done=%b want 000000ff 1", load_val, done);
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = 3'b0;
        addr = '0; store_data = '0; mem_ready = 1'b0; mem_rdata = '0;
        test_reset();
        test_sw();
        test_sb();
        test_lh_delayed();
        test_misaligned();
        test_illegal_funct3();
        test_timeout();
        test_back_to_back();
        test_ready_outside_req();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
